// File: rtl/mux8_rr_if.sv
// Request/grant bundle between the round-robin scheduler and its requesters.
interface mux8_rr_if;
  logic       en;
  logic [7:0] req;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       busy;
  logic [2:0] last;

  // Scheduler side: samples requests, drives select/grant status.
  modport master (
    input  en,
    input  req,
    output sel,
    output grant,
    output busy,
    output last
  );

  // Requester side: drives requests, observes select/grant status.
  modport slave (
    output en,
    output req,
    input  sel,
    input  grant,
    input  busy,
    input  last
  );
endinterface

// File: rtl/mux8_rr_scheduler.sv
// Round-robin scheduler sharing one 8:1 mux select among 8 requesters,
// with each grant bounded to HOLD_MAX consecutive cycles.
module mux8_rr_scheduler #(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  mux8_rr_if.master bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [7:0]       grant_q, grant_d;
  logic             busy_q, busy_d;
  logic [2:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       winner;
  logic             found;
  logic             release_c;

  // Scan requests starting just after the last granted index, wrapping 7->0.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!found && bus.req[3'(last_q + 3'(i + 1))]) begin
        winner = 3'(last_q + 3'(i + 1));
        found  = 1'b1;
      end
    end
  end

  // Current grant ends on request drop, hold limit, or disable.
  assign release_c = !bus.req[sel_q] || (cnt_q == CNT_W'(HOLD_MAX)) || !bus.en;

  // Next-state and registered-output values.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        grant_d = 8'd0;
        busy_d  = 1'b0;
        if (bus.en && found) begin
          state_d = GRANT;
          sel_d   = winner;
          last_d  = winner;
          grant_d = 8'(1) << winner;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANT: begin
        if (!release_c) begin
          // Below HOLD_MAX here, so the increment cannot overshoot it.
          cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.en && found) begin
          // Zero-bubble handover; released requester is scanned last.
          sel_d   = winner;
          last_d  = winner;
          grant_d = 8'(1) << winner;
          busy_d  = 1'b1;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
          grant_d = 8'd0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 8'd0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; reset drops any active grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 3'd0;
      grant_q <= 8'd0;
      busy_q  <= 1'b0;
      last_q  <= 3'd7;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;
  assign bus.last  = last_q;

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Directed bench for mux8_rr_scheduler with hand-computed expectations.
module tb_mux8_rr_scheduler;

  logic clk;
  logic rst_n;
  int   err_cnt;
  int   chk_cnt;

  mux8_rr_if bus ();

  mux8_rr_scheduler #(
    .HOLD_MAX (4),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle past it before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [7:0] e_sel,
                             input logic [7:0] e_grant, input logic [7:0] e_busy);
    check({tag, ".sel"},   8'(bus.sel),  e_sel);
    check({tag, ".grant"}, bus.grant,    e_grant);
    check({tag, ".busy"},  8'(bus.busy), e_busy);
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 8'd0, 8'h00, 8'd0);
    check("reset.last", 8'(bus.last), 8'd7);
    rst_n = 1'b1;
  endtask

  initial begin
    int seq [5];
    err_cnt = 0;
    chk_cnt = 0;
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.req = 8'h00;

    // Alternating requesters rotate every HOLD_MAX cycles, no idle gap.
    apply_reset();
    seq = '{1, 3, 5, 7, 1};
    bus.en  = 1'b1;
    bus.req = 8'b1010_1010;
    foreach (seq[k]) begin
      for (int c = 0; c < 4; c++) begin
        step();
        check_state("rotate", 8'(seq[k]), 8'(1 << seq[k]), 8'd1);
      end
    end
    bus.req = 8'h00;
    step();
    check_state("rotate_idle", 8'd1, 8'h00, 8'd0);
    check("rotate_idle.last", 8'(bus.last), 8'd1);

    // Two-cycle pulse on req[4]; sel/last hold after release.
    apply_reset();
    bus.en  = 1'b1;
    bus.req = 8'b0001_0000;
    step();
    check_state("pulse1", 8'd4, 8'h10, 8'd1);
    step();
    check_state("pulse2", 8'd4, 8'h10, 8'd1);
    bus.req = 8'h00;
    step();
    check_state("pulse_rel", 8'd4, 8'h00, 8'd0);
    check("pulse_rel.last", 8'(bus.last), 8'd4);

    // Sole requester is re-granted back to back at the hold limit.
    bus.req = 8'b0100_0000;
    for (int c = 0; c < 10; c++) begin
      step();
      check_state("solo", 8'd6, 8'h40, 8'd1);
    end
    bus.req = 8'h00;
    step();
    check_state("solo_rel", 8'd6, 8'h00, 8'd0);

    // Late request does not pre-empt; wrap order after last=2 is 3 then 0.
    bus.req = 8'b0000_0100;
    step();
    check_state("wrap_g2", 8'd2, 8'h04, 8'd1);
    bus.req = 8'b0000_0101;
    step();
    check_state("wrap_nopreempt", 8'd2, 8'h04, 8'd1);
    bus.req = 8'b0000_1001;
    step();
    check_state("wrap_g3", 8'd3, 8'h08, 8'd1);
    check("wrap_g3.last", 8'(bus.last), 8'd3);
    bus.req = 8'b0000_0001;
    step();
    check_state("wrap_g0", 8'd0, 8'h01, 8'd1);
    bus.req = 8'h00;
    step();
    check_state("wrap_idle", 8'd0, 8'h00, 8'd0);

    // Enable low mid-grant releases; no grants while disabled; resume after last.
    bus.req = 8'hFF;
    step();
    check_state("en_g1", 8'd1, 8'h02, 8'd1);
    bus.en = 1'b0;
    step();
    check_state("en_off", 8'd1, 8'h00, 8'd0);
    step();
    check_state("en_off2", 8'd1, 8'h00, 8'd0);
    check("en_off2.last", 8'(bus.last), 8'd1);
    bus.en = 1'b1;
    step();
    check_state("en_resume", 8'd2, 8'h04, 8'd1);

    // Asynchronous reset between edges clears the grant immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 8'd0, 8'h00, 8'd0);
    check("async_rst.last", 8'(bus.last), 8'd7);
    #2;
    rst_n = 1'b1;
    step();
    check_state("post_rst", 8'd0, 8'h01, 8'd1);
    check("post_rst.last", 8'(bus.last), 8'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
